id_stage_reg: RTL

Parametrised decode stage with an integrated register file and a registered ID/EX pipeline boundary. It extracts register and immediate fields from a MIPS32 instruction. It reads operands with write-back bypass and detects load-use hazards. It captures everything into an ID/EX register that supports stall, flush and bubble insertion. It sits between the IF/ID register and the EX stage of the pipelined core and is fed by the WB stage's write port.

---
 rtl/id_stage_reg.sv | 134 +++++++++++++
 1 files changed

// File: rtl/id_stage_reg.sv
// MIPS32 decode stage: field/immediate extraction, register file with WB bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_id,
    input  logic [DATA_W-1:0] pc_id,
    input  logic              valid_id,
    input  logic              rs2_use,
    input  logic              zext_imm,
    input  logic              mem_read_id,
    input  logic              reg_wr_wb,
    input  logic [4:0]        wr_addr_wb,
    input  logic [DATA_W-1:0] wr_data_wb,
    input  logic              stall_in,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              valid_ex,
    output logic              mem_read_ex,
    output logic [DATA_W-1:0] rd1_ex,
    output logic [DATA_W-1:0] rd2_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [DATA_W-1:0] pc_target_j_ex,
    output logic [4:0]        rs1_ex,
    output logic [4:0]        rs2_ex,
    output logic [4:0]        rd_ex
);

    localparam int unsigned AW = $clog2(NREG);

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc_target_j;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
    } idex_t;

    logic [DATA_W-1:0] regs [NREG];
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc_target_j;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              wr_ok;
    idex_t             idex_d;
    idex_t             idex_q;
    logic              unused_bits;

    // Non-zero address inside the implemented register range.
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < NREG);
    endfunction

    assign rs1         = instr_id[25:21];
    assign rs2         = rs2_use ? instr_id[20:16] : 5'd0;
    assign rd          = rs2_use ? instr_id[15:11] : instr_id[20:16];
    assign imm         = {{(DATA_W-16){~zext_imm & instr_id[15]}}, instr_id[15:0]};
    assign pc_target_j = {pc_id[DATA_W-1:28], instr_id[25:0], 2'b00};
    assign wr_ok       = reg_wr_wb && addr_ok(wr_addr_wb);
    assign unused_bits = ^{instr_id[31:26], pc_id[27:0]};

    // Operand read; a same-cycle WB write to the read address is forwarded.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (addr_ok(rs1)) begin
            rd1 = (wr_ok && (wr_addr_wb == rs1)) ? wr_data_wb : regs[rs1[AW-1:0]];
        end
        if (addr_ok(rs2)) begin
            rd2 = (wr_ok && (wr_addr_wb == rs2)) ? wr_data_wb : regs[rs2[AW-1:0]];
        end
    end

    assign hazard_stall = valid_id && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                          ((idex_q.rd == rs1) || (rs2_use && (idex_q.rd == rs2)));

    always_comb begin
        idex_d             = '0;
        idex_d.valid       = valid_id;
        idex_d.mem_read    = mem_read_id && valid_id;
        idex_d.rd1         = rd1;
        idex_d.rd2         = rd2;
        idex_d.imm         = imm;
        idex_d.pc_target_j = pc_target_j;
        idex_d.rs1         = rs1;
        idex_d.rs2         = rs2;
        idex_d.rd          = rd;
    end

    // Register file; writes are independent of pipeline stall/flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr_wb[AW-1:0]] <= wr_data_wb;
        end
    end

    // ID/EX: flush beats hold, hold beats the hazard bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            idex_q <= '0;
        end else if (!stall_in) begin
            if (hazard_stall) begin
                idex_q <= '0;
            end else begin
                idex_q <= idex_d;
            end
        end
    end

    assign valid_ex       = idex_q.valid;
    assign mem_read_ex    = idex_q.mem_read;
    assign rd1_ex         = idex_q.rd1;
    assign rd2_ex         = idex_q.rd2;
    assign imm_ex         = idex_q.imm;
    assign pc_target_j_ex = idex_q.pc_target_j;
    assign rs1_ex         = idex_q.rs1;
    assign rs2_ex         = idex_q.rs2;
    assign rd_ex          = idex_q.rd;

endmodule
